// File: rtl/audio_pkg.sv
// Shared constants and helpers for the I2S audio transmit path.
package audio_pkg;

    localparam int AUDIO_WIDTH = 16;

    typedef enum logic {
        CHAN_LEFT  = 1'b0,
        CHAN_RIGHT = 1'b1
    } chan_e;

    function automatic int frame_len(input int width);
        return 2 * width;
    endfunction

    // Word select leads data by one bclk, so it flips one bit early.
    function automatic chan_e ws_for_bit(input int bit_idx, input int width);
        if (bit_idx >= width - 1 && bit_idx <= 2 * width - 2)
            return CHAN_RIGHT;
        return CHAN_LEFT;
    endfunction

endpackage

// File: rtl/audio_bclk_divider.sv
// Free-running bit clock divider with a strobe on the clk edge where bclk falls.
module audio_bclk_divider
    import audio_pkg::*;
#(
    parameter int half_period = 1
) (
    input  logic clk,
    input  logic reset,
    output logic o_bclk,
    output logic o_fall
);

    localparam int cw = (half_period > 1) ? $clog2(half_period) : 1;

    logic [cw-1:0] div;
    logic          wrap;

    assign wrap   = (div == cw'(half_period - 1));
    assign o_fall = wrap && o_bclk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div    <= '0;
            o_bclk <= 1'b0;
        end else if (wrap) begin
            div    <= '0;
            o_bclk <= ~o_bclk;
        end else begin
            div    <= div + 1'b1;
        end
    end

endmodule

// File: rtl/audio_i2s_transmitter.sv
// I2S transmitter: one-entry stereo holding register feeding a frame shifter.
module audio_i2s_transmitter
    import audio_pkg::*;
#(
    parameter int audio_width      = AUDIO_WIDTH,
    parameter int bclk_half_period = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [audio_width-1:0] i_left,
    input  logic [audio_width-1:0] i_right,
    output logic                   o_bclk,
    output logic                   o_lrclk,
    output logic                   o_sdata,
    output logic                   o_underrun
);

    localparam int fb    = frame_len(audio_width);
    localparam int cnt_w = $clog2(fb);

    logic [cnt_w-1:0] bit_cnt;
    logic [cnt_w-1:0] bit_nxt;
    logic [fb-1:0]    shreg;
    logic [fb-1:0]    hold;
    logic             full;
    logic             fall;
    logic             wrap;
    logic             load;
    logic             accept;
    chan_e            ws_nxt;

    audio_bclk_divider #(
        .half_period(bclk_half_period)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .o_bclk(o_bclk),
        .o_fall(fall)
    );

    assign i_ready = !full && !reset;
    assign accept  = i_valid && i_ready;
    assign wrap    = (bit_cnt == cnt_w'(fb - 1));
    assign load    = fall && wrap;
    assign bit_nxt = wrap ? '0 : bit_cnt + 1'b1;
    assign ws_nxt  = ws_for_bit(int'(bit_nxt), audio_width);

    // Accept never coincides with a load of a full register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            hold <= '0;
        end else if (load && full) begin
            full <= 1'b0;
        end else if (accept) begin
            full <= 1'b1;
            hold <= {i_left, i_right};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= cnt_w'(fb - 1);
            shreg      <= '0;
            o_sdata    <= 1'b0;
            o_lrclk    <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_underrun <= 1'b0;
            if (fall) begin
                bit_cnt <= bit_nxt;
                o_lrclk <= ws_nxt;
                if (wrap) begin
                    if (full) begin
                        shreg   <= hold;
                        o_sdata <= hold[fb-1];
                    end else begin
                        shreg      <= '0;
                        o_sdata    <= 1'b0;
                        o_underrun <= 1'b1;
                    end
                end else begin
                    shreg   <= {shreg[fb-2:0], 1'b0};
                    o_sdata <= shreg[fb-2];
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_transmitter.sv
// Scoreboard bench for the I2S transmitter at bclk_half_period 1 and 3.
module tb_audio_i2s_transmitter;

    localparam logic [31:0] LR_MASK = 32'h7FFF_8000;

    typedef struct {
        logic [31:0] data;
        int          acc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst3 = 1'b1;
    logic        sel = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_left = '0;
    logic [15:0] i_right = '0;

    logic v1, rdy1, b1, lr1, sd1, ur1;
    logic v3, rdy3, b3, lr3, sd3, ur3;
    logic m_rst, m_ready, m_bclk, m_lr, m_sdata, m_ur;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    sb_t sb[$];

    int          bitpos = 31;
    logic        prev_b = 1'b0;
    logic        in_frame = 1'b0;
    logic        have_start = 1'b0;
    logic        have_rise = 1'b0;
    int          start_cyc = 0;
    int          last_rise = 0;
    int          frame_len = 0;
    int          rise_period = 0;
    int          load_cyc = 0;
    int          frames_done = 0;
    logic [31:0] frame = '0;
    logic [31:0] lr = '0;
    logic [31:0] cur_exp = '0;
    logic        exp_ur;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign v1      = i_valid && !sel;
    assign v3      = i_valid && sel;
    assign m_rst   = sel ? rst3 : rst;
    assign m_ready = sel ? rdy3 : rdy1;
    assign m_bclk  = sel ? b3 : b1;
    assign m_lr    = sel ? lr3 : lr1;
    assign m_sdata = sel ? sd3 : sd1;
    assign m_ur    = sel ? ur3 : ur1;

    audio_i2s_transmitter dut (
        .clk       (clk),
        .reset     (rst),
        .i_valid   (v1),
        .i_ready   (rdy1),
        .i_left    (i_left),
        .i_right   (i_right),
        .o_bclk    (b1),
        .o_lrclk   (lr1),
        .o_sdata   (sd1),
        .o_underrun(ur1)
    );

    audio_i2s_transmitter #(
        .bclk_half_period(3)
    ) dut3 (
        .clk       (clk),
        .reset     (rst3),
        .i_valid   (v3),
        .i_ready   (rdy3),
        .i_left    (i_left),
        .i_right   (i_right),
        .o_bclk    (b3),
        .o_lrclk   (lr3),
        .o_sdata   (sd3),
        .o_underrun(ur3)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic monitor_step();
        logic b;
        logic fell;
        b    = m_bclk;
        fell = prev_b && !b;
        if (m_rst) begin
            prev_b     = 1'b0;
            bitpos     = 31;
            in_frame   = 1'b0;
            have_start = 1'b0;
            have_rise  = 1'b0;
        end else begin
            if (fell) begin
                bitpos = (bitpos == 31) ? 0 : bitpos + 1;
                if (bitpos == 0) begin
                    exp_ur = !(sb.size() > 0 && sb[0].acc < cyc);
                    check("underrun", m_ur, exp_ur);
                    cur_exp = '0;
                    if (!exp_ur) begin
                        cur_exp = sb[0].data;
                        void'(sb.pop_front());
                    end
                    if (have_start) frame_len = cyc - start_cyc;
                    start_cyc  = cyc;
                    have_start = 1'b1;
                    load_cyc   = cyc;
                    in_frame   = 1'b1;
                end
            end else if (!prev_b && b) begin
                if (have_rise) rise_period = cyc - last_rise;
                last_rise = cyc;
                have_rise = 1'b1;
                if (in_frame) begin
                    frame[31-bitpos] = m_sdata;
                    lr[bitpos]       = m_lr;
                    if (bitpos == 31) begin
                        check("frame", frame, cur_exp);
                        check("lrclk", lr, LR_MASK);
                        frames_done++;
                    end
                end
            end
            if (m_ur && !(fell && bitpos == 0))
                check("spurious_ur", m_ur, 1'b0);
            prev_b = b;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        int t;
        int acc;
        t       = 0;
        i_left  = l;
        i_right = r;
        i_valid = 1'b1;
        #1;
        while (!m_ready && t < 5000) begin
            tick();
            t++;
        end
        if (!m_ready) begin
            check("send_ready", m_ready, 1'b1);
            i_valid = 1'b0;
        end else begin
            acc = cyc + 1;
            @(posedge clk);
            sb.push_back('{{l, r}, acc});
            #1;
            i_valid = 1'b0;
        end
    endtask

    task automatic wait_frames(input int n);
        int base;
        int t;
        base = frames_done;
        t    = 0;
        while (frames_done < base + n && t < 20000) begin
            tick();
            t++;
        end
        check("frames", frames_done - base, n);
    endtask

    initial begin
        logic sd_seen;
        int   t;

        tick();
        tick();
        check("rst_bclk", m_bclk, 1'b0);
        check("rst_lrclk", m_lr, 1'b0);
        check("rst_sdata", m_sdata, 1'b0);
        check("rst_ur", m_ur, 1'b0);
        check("rst_ready", m_ready, 1'b0);

        @(negedge clk);
        rst     = 1'b0;
        sd_seen = 1'b0;
        for (int k = 1; k <= 66; k++) begin
            tick();
            sd_seen = sd_seen | m_sdata;
            if (k == 1) check("bclk_rise", m_bclk, 1'b1);
            if (k == 2) begin
                check("bclk_fall", m_bclk, 1'b0);
                check("ur_first", m_ur, 1'b1);
                check("ready_idle", m_ready, 1'b1);
            end
            if (k == 65) check("ur_gap", m_ur, 1'b0);
            if (k == 66) check("ur_period", m_ur, 1'b1);
        end
        check("idle_sdata", sd_seen, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        tick();
        @(negedge clk);
        rst = 1'b0;
        send(16'hC000, 16'h1100);
        wait_frames(2);
        check("frame_len", frame_len, 64);

        send(16'h2000, 16'h2100);
        check("bp_ready_low", m_ready, 1'b0);
        t = 0;
        while (!m_ready && t < 500) begin
            tick();
            t++;
        end
        check("ready_at_load", load_cyc, cyc);
        send(16'h3000, 16'h3100);
        wait_frames(3);

        for (int i = 1; i <= 12; i++)
            send(16'(i), 16'(16'h0100 + i));
        wait_frames(2);

        send(16'h5555, 16'h6666);
        send(16'h7777, 16'h8888);
        t = 0;
        while (!(bitpos == 20 && !m_ready) && t < 500) begin
            tick();
            t++;
        end
        check("mid_bitpos", bitpos, 20);
        rst = 1'b1;
        #1;
        check("mid_bclk", m_bclk, 1'b0);
        check("mid_lrclk", m_lr, 1'b0);
        check("mid_sdata", m_sdata, 1'b0);
        check("mid_ur", m_ur, 1'b0);
        check("mid_ready", m_ready, 1'b0);
        sb.delete();
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        wait_frames(1);

        tick();
        sel = 1'b1;
        sb.delete();
        tick();
        tick();
        @(negedge clk);
        rst3 = 1'b0;
        send(16'hE001, 16'h0101);
        wait_frames(2);
        check("frame_len3", frame_len, 192);
        check("bclk_period3", rise_period, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
